onchip_memory_pipelined: RTL
============================

// Module: onchip_memory_pipelined
// PURPOSE
// Parametrised single-port on-chip RAM with an Avalon-MM pipelined slave (s1) for the Nios II system.
// Generalises the fixed 32-bit/16000-word memory: width, depth and read latency are set by parameters.
// Adds readdatavalid, waitrequest, an optional post-reset clear sweep, out-of-range detection and clken stalls.
// PARAMETERS
// DATA_W      32        data width in bits; multiple of 8
// DEPTH       16000     number of words; 2 <= DEPTH <= 2**ADDR_W
// ADDR_W      14        word-address width
// READ_LAT    1         read latency in cycles: 1 = unregistered q, 2 = output register
// CLEAR_EN    0         1 = write CLEAR_VAL to every word after reset
// CLEAR_VAL   0         DATA_W-bit fill value used by the clear sweep
// PORTS
// clk            in   1         system clock
// reset_n        in   1         synchronous reset, active low
// address        in   ADDR_W    word address
// byteenable     in   DATA_W/8  byte lanes for writes
// chipselect     in   1         slave select
// read           in   1         read request
// write          in   1         write request
// writedata      in   DATA_W    write data
// clken          in   1         clock enable; 0 stalls the read pipeline and blocks accepts
// reset_req      in   1         reset-request fence; gates clken like clken=0
// waitrequest    out  1         1 = command not accepted this cycle
// readdata       out  DATA_W    read data, valid when readdatavalid=1
// readdatavalid  out  1         one pulse per accepted read
// range_err      out  1         sticky: an access used address >= DEPTH
// BEHAVIOUR
// - en = clken & ~reset_req. Command accepted when chipselect & (read|write) & ~waitrequest.
// - waitrequest = (state==CLEAR) | ~en. read&write together: write wins, read dropped (no readdatavalid).
// - Reset (reset_n=0 at clk edge): readdata=0, readdatavalid=0, range_err=0, pipeline flushed, state=CLEAR
//   if CLEAR_EN else IDLE. RAM contents are not touched by reset itself.
// - FSM: CLEAR -> sweep ptr 0..DEPTH-1, one word/cycle while en, all byte lanes; ptr==DEPTH-1 -> IDLE.
//   IDLE: serves commands. Reset mid-sweep restarts the sweep at 0. Clear takes DEPTH cycles with en=1.
// - Write: accepted write with address < DEPTH updates enabled byte lanes on that edge; others kept.
// - Read: accepted at edge N -> readdata/readdatavalid at edge N+READ_LAT; one read per cycle sustained.
// - Stall: en=0 freezes every pipeline stage; readdatavalid/readdata hold. No data lost, none duplicated.
// - Read-during-write same address (back-to-back write then read): read returns new data; RAM is
//   write-first. Write then read in consecutive cycles always sees written data.
// - address >= DEPTH: write dropped, read returns 0 with normal latency/valid; range_err set, cleared only by reset.
// - Max outstanding reads = READ_LAT; no backpressure on readdata (master must accept).
// STRUCTURE
// - Package onchip_mem_pkg: state enum {IDLE, CLEAR}, function be_mask(byteenable) -> DATA_W mask,
//   localparam BE_W = DATA_W/8, READ_LAT legality check.
// - Sub-module onchip_ram_sp: inferred byte-enabled single-port RAM (DATA_W x DEPTH, write-first,
//   1-cycle q, clock enable). Top holds FSM, sweep counter, valid pipeline, output register, error flag.
// - Elaboration error if DATA_W%8!=0, READ_LAT not in {1,2}, or DEPTH > 2**ADDR_W.
// TESTING
// - CLEAR_EN=1, DEPTH=16: release reset -> waitrequest=1 exactly 16 cycles, then every read returns CLEAR_VAL.
// - Write 0xDEADBEEF @5, byteenable=4'b0101 over 0x0 -> read @5 returns 0x00AD00EF, valid at +READ_LAT.
// - READ_LAT=2: reads @0..7 back-to-back -> 8 consecutive readdatavalid pulses, in order, first 2 cycles after first accept.
// - clken=0 for 3 cycles mid-burst -> outputs hold, no extra/missing valids, data order preserved.
// - Read @DEPTH (out of range) -> readdata=0 with valid, range_err=1 and stays 1 until reset_n=0.
// - reset_n=0 during sweep ptr=7 -> outputs zero next edge, sweep restarts at 0, full DEPTH cycles of waitrequest.

Source files
------------

// File: rtl/onchip_memory_pipelined_pkg.sv
// Shared constants and helpers for the pipelined on-chip RAM slice:
// FSM state encodings, byte-enable expansion and read-latency legality.
package onchip_mem_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Widest byte-lane count be_mask can expand (512-bit data).
    localparam int MAX_BE_W = 64;

    function automatic logic [8*MAX_BE_W-1:0] be_mask(input logic [MAX_BE_W-1:0] be);
        logic [8*MAX_BE_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    function automatic bit read_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/onchip_memory_pipelined_if.sv
// Avalon-MM pipelined slave bundle for the on-chip RAM, plus the enable/fence
// inputs and a debug view of the controller state.
interface onchip_memory_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    localparam int BE_W = DATA_W / 8;

    // Handshake: a command is taken on a clock edge where chipselect & (read|write)
    // is high and waitrequest is low; the master holds the command until then.
    // Each taken read yields exactly one readdatavalid beat, which the master
    // must consume (there is no backpressure on the response side).
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic              reset_req;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              range_err;
    logic [0:0]        fsm_state;

    modport master (
        output address, byteenable, chipselect, read, write, writedata, clken, reset_req,
        input  waitrequest, readdata, readdatavalid, range_err, fsm_state
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata, clken, reset_req,
        output waitrequest, readdata, readdatavalid, range_err, fsm_state
    );

endinterface

// File: rtl/onchip_memory_pipelined_ram_sp.sv
// Single-port byte-masked RAM, write-first, registered q, clock enable.
module onchip_ram_sp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16000,
    parameter int IDX_W  = 14
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    assign merged = (mem[addr] & ~wmask) | (wdata & wmask);

    // On a write, q shows the freshly merged word rather than the old contents.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= merged;
                q         <= merged;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Parametrised single-port on-chip RAM behind an Avalon-MM pipelined slave,
// with optional post-reset clear sweep, range checking and clock-enable stalls.
module onchip_memory_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16000,
    parameter int                ADDR_W    = 14,
    parameter int                READ_LAT  = 1,
    parameter int                CLEAR_EN  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    onchip_memory_pipelined_if.slave s1
);
    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(DEPTH - 1);

    if ((DATA_W % 8 != 0) || (DATA_W / 8 > MAX_BE_W)) begin : g_bad_width
        $error("onchip_memory_pipelined: DATA_W must be a multiple of 8 within be_mask range");
    end
    if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
        $error("onchip_memory_pipelined: READ_LAT must be 1 or 2");
    end
    if ((DEPTH < 2) || (64'(DEPTH) > (64'd1 << ADDR_W))) begin : g_bad_depth
        $error("onchip_memory_pipelined: DEPTH must be in 2..2**ADDR_W");
    end

    logic              en, clearing, wait_req, cmd, wr_acc, rd_acc, in_range;
    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_mask, ram_q, wr_mask;
    logic              s1_valid, s1_oor;
    logic [DATA_W-1:0] s1_data;
    logic              range_err;

    assign en       = s1.clken & ~s1.reset_req;
    assign clearing = (state == ST_CLEAR);
    assign wait_req = clearing | ~en;
    assign cmd      = s1.chipselect & (s1.read | s1.write) & ~wait_req;
    assign wr_acc   = cmd & s1.write;
    assign rd_acc   = cmd & s1.read & ~s1.write;
    assign in_range = ({1'b0, s1.address} < DEPTH_V);
    assign wr_mask  = DATA_W'(be_mask(MAX_BE_W'(s1.byteenable)));

    // The sweep owns the RAM port while clearing; commands are held off by waitrequest.
    assign ram_we    = clearing | (wr_acc & in_range);
    assign ram_addr  = clearing ? ptr : s1.address[IDX_W-1:0];
    assign ram_wdata = clearing ? CLEAR_VAL : s1.writedata;
    assign ram_mask  = clearing ? '1 : wr_mask;

    onchip_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .ce    (en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .wmask (ram_mask),
        .q     (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
            ptr   <= '0;
        end else if (en && clearing) begin
            if (ptr == LAST_PTR) begin
                state <= ST_IDLE;
                ptr   <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_oor    <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (en) begin
                s1_valid <= rd_acc;
                s1_oor   <= ~in_range;
            end
            if (cmd && !in_range) begin
                range_err <= 1'b1;
            end
        end
    end

    // Out-of-range reads and idle slots present zero instead of stale RAM q.
    assign s1_data = (s1_valid && !s1_oor) ? ram_q : '0;

    if (READ_LAT == 2) begin : g_lat2
        logic              s2_valid;
        logic [DATA_W-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else if (en) begin
                s2_valid <= s1_valid;
                s2_data  <= s1_data;
            end
        end

        assign s1.readdatavalid = s2_valid;
        assign s1.readdata      = s2_data;
    end else begin : g_lat1
        assign s1.readdatavalid = s1_valid;
        assign s1.readdata      = s1_data;
    end

    assign s1.waitrequest = wait_req;
    assign s1.range_err   = range_err;
    assign s1.fsm_state   = state;

endmodule
